alu_share_arbiter: RTL and testbench



---
 rtl/alu_share_arbiter.sv | 107 ++++++++++
 tb/tb_alu_share_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one add/AND datapath between two requesters.
// Each grant runs IDLE -> EXEC -> RESP; all outputs come straight from flops.
module alu_share_arbiter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [1:0]       op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [1:0]       op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t           state, state_nxt;
    logic             grant;
    logic             win_id;
    logic             last_gnt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             id_q;
    logic [WIDTH:0]   alu_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // On a tie the requester that was not granted last wins.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        win_id    = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant     = 1'b1;
                    win_id    = (req0 && req1) ? ~last_gnt : req1;
                    state_nxt = EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        alu_sum = '0;
        case (op_q)
            2'b00:   alu_sum = '0;
            2'b10:   alu_sum = {1'b0, a_q & b_q};
            default: alu_sum = {1'b0, a_q} + {1'b0, b_q};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt  <= 1'b1;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            gnt0      <= grant && !win_id;
            gnt1      <= grant && win_id;
            rsp_valid <= (state == EXEC);
            busy      <= (state_nxt != IDLE);
            if (grant) begin
                last_gnt <= win_id;
                id_q     <= win_id;
                op_q     <= win_id ? op1 : op0;
                a_q      <= win_id ? a1 : a0;
                b_q      <= win_id ? b1 : b0;
            end
            if (state == EXEC) begin
                result <= alu_sum[WIDTH-1:0];
                carry  <= alu_sum[WIDTH];
                rsp_id <= id_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and randomized checks of alu_share_arbiter against a
// transaction-level reference model (grant times, fairness, arithmetic).
module tb_alu_share_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0, req1;
    logic [1:0] op0, op1;
    logic [3:0] a0, b0, a1, b1;
    logic       gnt0, gnt1, rsp_valid, rsp_id, carry, busy;
    logic [3:0] result;

    int unsigned n_vec;
    int unsigned n_err;

    // Reference model: cycles left in the current transaction, fairness
    // pointer, and the result captured at grant time.
    int unsigned m_left;
    bit          m_ptr;
    bit          m_gnt0, m_gnt1, m_rv, m_id, m_c, m_busy;
    bit   [3:0]  m_res;
    bit   [3:0]  p_res;
    bit          p_c, p_id;

    alu_share_arbiter #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .op0       (op0),
        .a0        (a0),
        .b0        (b0),
        .req1      (req1),
        .op1       (op1),
        .a1        (a1),
        .b1        (b1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .result    (result),
        .carry     (carry),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("gnt0",      {7'd0, gnt0},      {7'd0, m_gnt0});
        chk("gnt1",      {7'd0, gnt1},      {7'd0, m_gnt1});
        chk("rsp_valid", {7'd0, rsp_valid}, {7'd0, m_rv});
        chk("rsp_id",    {7'd0, rsp_id},    {7'd0, m_id});
        chk("result",    {4'd0, result},    {4'd0, m_res});
        chk("carry",     {7'd0, carry},     {7'd0, m_c});
        chk("busy",      {7'd0, busy},      {7'd0, m_busy});
    endtask

    task automatic model_reset();
        m_left = 0;
        m_ptr  = 1'b1;
        m_gnt0 = 0; m_gnt1 = 0; m_rv = 0; m_id = 0; m_c = 0; m_busy = 0;
        m_res  = '0;
    endtask

    // Arithmetic reference: plain integer sum split into result and carry.
    task automatic compute(input bit [1:0] op, input bit [3:0] a, input bit [3:0] b,
                           output bit [3:0] r, output bit c);
        int sum;
        if (op == 2'b00) begin
            r = 0; c = 0;
        end else if (op == 2'b10) begin
            r = a & b; c = 0;
        end else begin
            sum = int'(a) + int'(b);
            r = 4'(sum % 16);
            c = (sum >= 16);
        end
    endtask

    // Advance the model by one clock edge using the inputs present now, then check.
    task automatic tick();
        bit w;
        if (m_left == 0 && (req0 || req1)) begin
            w = (req0 && req1) ? !m_ptr : req1;
            m_ptr = w;
            p_id  = w;
            if (w) compute(op1, a1, b1, p_res, p_c);
            else   compute(op0, a0, b0, p_res, p_c);
            m_gnt0 = !w; m_gnt1 = w; m_rv = 0; m_busy = 1; m_left = 2;
        end else if (m_left == 2) begin
            m_gnt0 = 0; m_gnt1 = 0; m_rv = 1; m_busy = 1; m_left = 1;
            m_res = p_res; m_c = p_c; m_id = p_id;
        end else begin
            m_gnt0 = 0; m_gnt1 = 0; m_rv = 0; m_busy = 0; m_left = 0;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all();
    endtask

    task automatic set0(input bit r, input bit [1:0] op, input bit [3:0] a, input bit [3:0] b);
        req0 = r; op0 = op; a0 = a; b0 = b;
    endtask

    task automatic set1(input bit r, input bit [1:0] op, input bit [3:0] a, input bit [3:0] b);
        req1 = r; op1 = op; a1 = a; b1 = b;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        set0(0, 2'b00, 4'h0, 4'h0);
        set1(0, 2'b00, 4'h0, 4'h0);
        #2;
        apply_reset();

        // Single add 9+8 from requester 0
        set0(1, 2'b01, 4'h9, 4'h8);
        tick();
        chk("add_gnt0", {7'd0, gnt0}, 8'd1);
        set0(0, 2'b01, 4'h9, 4'h8);
        tick();
        chk("add_result", {4'd0, result}, 8'h01);
        chk("add_carry", {7'd0, carry}, 8'd1);
        tick();
        tick();

        // Single AND and zero-op from requester 1
        set1(1, 2'b10, 4'hC, 4'hA);
        tick();
        set1(0, 2'b10, 4'hC, 4'hA);
        tick();
        chk("and_result", {4'd0, result}, 8'h08);
        tick();
        set1(1, 2'b00, 4'hC, 4'hA);
        tick();
        set1(0, 2'b00, 4'hC, 4'hA);
        tick();
        chk("zero_result", {4'd0, result}, 8'h00);
        tick();

        // Tie from reset: both held, grants alternate 0,1,0,1
        apply_reset();
        set0(1, 2'b01, 4'h3, 4'h4);
        set1(1, 2'b10, 4'h7, 4'hE);
        for (int i = 0; i < 12; i++) tick();
        set0(0, 2'b01, 4'h3, 4'h4);
        set1(0, 2'b10, 4'h7, 4'hE);
        for (int i = 0; i < 3; i++) tick();

        // Operands change right after the grant
        set0(1, 2'b01, 4'h5, 4'h6);
        tick();
        set0(0, 2'b01, 4'hF, 4'hF);
        tick();
        chk("stable_result", {4'd0, result}, 8'h0B);
        tick();

        // Op 11 with F+F
        set1(1, 2'b11, 4'hF, 4'hF);
        tick();
        set1(0, 2'b11, 4'hF, 4'hF);
        tick();
        chk("op11_result", {4'd0, result}, 8'h0E);
        chk("op11_carry", {7'd0, carry}, 8'd1);
        tick();

        // Reset asserted mid-EXEC aborts the op; no stray response afterwards
        set0(1, 2'b01, 4'h7, 4'h7);
        tick();
        set0(0, 2'b01, 4'h7, 4'h7);
        apply_reset();
        for (int i = 0; i < 4; i++) tick();

        // Randomized traffic with operands churning every cycle
        for (int i = 0; i < 400; i++) begin
            set0(1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom), 4'($urandom));
            set1(1'($urandom_range(0, 1)), 2'($urandom), 4'($urandom), 4'($urandom));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
